flag_ctrl: RTL

Controller for the CPU's four-bit flag register bank (C, V, N, Z). It merges per-instruction flag masks into the single register write enable and saves/restores flags on a small hardware stack for interrupt entry and return. It also evaluates branch conditions against the architectural flags. It sits between the decode/ALU stage and the flag registers; the flag register's own reset is independent of this block.

---
 rtl/flag_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/flag_ctrl.sv
// -----------------------------------------------------------------------------
// flag_ctrl
//
// Controller for the four-bit flag register bank {C,V,N,Z}. It does three jobs:
//   * merges a per-flag ALU mask into one write enable / write data pair,
//   * saves flags on a small hardware stack (push) and restores them (pop)
//     through a one-cycle RESTORE state,
//   * optionally evaluates branch conditions against the architectural flags.
// The flag register itself lives outside this block and has its own reset.
//
// Configuration macro:
//   FLAG_CTRL_COND_EN  defined   -> condition evaluator present
//                      undefined -> cond_done / cond_taken tied to 0,
//                                   cond_valid / cond_code ignored
//
// Parameters:
//   STACK_DEPTH  number of saved flag entries (power of two, 2..16)
//   PTR_W        log2(STACK_DEPTH)
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   alu_valid    ALU result flags valid this cycle
//   alu_mask     per-flag update mask {C,V,N,Z}, 1 = take alu_flags bit
//   alu_flags    new flags {C,V,N,Z} from the ALU
//   push         save current flags on the stack
//   pop          restore the most recently saved flags
//   cond_valid   branch condition evaluation request
//   cond_code    condition selector
//   flags_q      current flag register outputs {C,V,N,Z}
//   flag_we      write enable to the flag register
//   flag_d       write data to the flag register {C,V,N,Z}
//   busy         restore in progress, no requests accepted
//   stack_empty  no saved entries
//   stack_full   STACK_DEPTH entries saved
//   stack_err    sticky error flag (cleared only by reset)
//   cond_done    one-cycle pulse, cond_taken valid
//   cond_taken   condition result
// -----------------------------------------------------------------------------
module flag_ctrl #(
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_valid,
  input  logic [3:0] alu_mask,
  input  logic [3:0] alu_flags,
  input  logic       push,
  input  logic       pop,
  input  logic       cond_valid,
  input  logic [2:0] cond_code,
  input  logic [3:0] flags_q,
  output logic       flag_we,
  output logic [3:0] flag_d,
  output logic       busy,
  output logic       stack_empty,
  output logic       stack_full,
  output logic       stack_err,
  output logic       cond_done,
  output logic       cond_taken
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(STACK_DEPTH);

  typedef enum logic {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [PTR_W:0] sp_q, sp_d;
  logic [PTR_W:0] sp_m1;
  logic [3:0]     stack_q [STACK_DEPTH];
  logic [3:0]     hold_q;
  logic           err_q, err_d;

  logic           do_push;
  logic           do_pop;
  logic           do_alu;
  logic           err_req;

  // Bitwise merge: masked bits come from the ALU, the rest keep their value.
  function automatic logic [3:0] merge_flags(input logic [3:0] mask,
                                             input logic [3:0] newf,
                                             input logic [3:0] oldf);
    return (mask & newf) | (~mask & oldf);
  endfunction

  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == DEPTH_C);
  assign stack_err   = err_q;
  assign sp_m1       = sp_q - 1'b1;

  // Request decode. Every illegal request is flagged and otherwise ignored;
  // an ALU update is dropped whenever pop is asserted (pop has priority).
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_alu  = 1'b0;
    err_req = 1'b0;
    if (state_q == RESTORE) begin
      err_req = alu_valid | push | pop;
    end else begin
      if (push && pop) begin
        err_req = 1'b1;
      end else if (push) begin
        if (stack_full) err_req = 1'b1;
        else            do_push = 1'b1;
      end else if (pop) begin
        if (stack_empty) err_req = 1'b1;
        else             do_pop  = 1'b1;
      end
      do_alu = alu_valid && !pop;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_pop) state_d = RESTORE;
      RESTORE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Write enable and busy are forced low while reset is held.
  always_comb begin
    flag_we = 1'b0;
    flag_d  = 4'b0000;
    busy    = 1'b0;
    if (rst_n) begin
      case (state_q)
        RESTORE: begin
          flag_we = 1'b1;
          flag_d  = hold_q;
          busy    = 1'b1;
        end
        default: begin
          if (do_alu) begin
            flag_we = 1'b1;
            flag_d  = merge_flags(alu_mask, alu_flags, flags_q);
          end
        end
      endcase
    end
  end

  // Stack pointer and sticky error
  always_comb begin
    sp_d  = sp_q;
    err_d = err_q | err_req;
    if (do_push)     sp_d = sp_q + 1'b1;
    else if (do_pop) sp_d = sp_m1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack storage and restore holding register carry no reset; a reset cycle
  // must not write them, so a reset arriving mid-restore leaves the stack intact.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      stack_q[sp_q[PTR_W-1:0]] <= flags_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_pop) begin
      hold_q <= stack_q[sp_m1[PTR_W-1:0]];
    end
  end

`ifdef FLAG_CTRL_COND_EN
  logic cond_done_q, cond_done_d;
  logic cond_taken_q, cond_taken_d;

  // Flag order is {C,V,N,Z}.
  function automatic logic cond_eval(input logic [2:0] code,
                                     input logic [3:0] f);
    logic c, v, n, z;
    c = f[3];
    v = f[2];
    n = f[1];
    z = f[0];
    case (code)
      3'b000:  return 1'b1;
      3'b001:  return z;
      3'b010:  return !z;
      3'b011:  return c;
      3'b100:  return !c;
      3'b101:  return n;
      3'b110:  return v;
      default: return n ^ v;
    endcase
  endfunction

  // Evaluation is independent of busy; the result holds between requests.
  always_comb begin
    cond_done_d  = cond_valid;
    cond_taken_d = cond_taken_q;
    if (cond_valid) cond_taken_d = cond_eval(cond_code, flags_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cond_done_q  <= 1'b0;
      cond_taken_q <= 1'b0;
    end else begin
      cond_done_q  <= cond_done_d;
      cond_taken_q <= cond_taken_d;
    end
  end

  assign cond_done  = cond_done_q;
  assign cond_taken = cond_taken_q;
`else
  logic unused_cond;
  assign unused_cond = ^{cond_valid, cond_code};
  assign cond_done   = 1'b0;
  assign cond_taken  = 1'b0;
`endif

endmodule
